// File: rtl/rob_pkg.sv
// Shared types, sizes and the age helper for the in-order retirement buffer.
package rob_pkg;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [DATA_W-1:0] pc;
        logic [4:0]        rd;
        logic              regwrite;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

    // Distance of an entry from head; smaller means older.
    function automatic logic [TAG_W-1:0] rob_age(input logic [TAG_W-1:0] index,
                                                 input logic [TAG_W-1:0] head);
        return index - head;
    endfunction

endpackage

// File: rtl/rob_pc_match.sv
// Combinational finder for the oldest valid, not-yet-done entry whose PC matches,
// skipping entries already claimed by a higher-priority completion port.
module rob_pc_match
    import rob_pkg::*;
(
    input  rob_entry_t        entries_i [DEPTH],
    input  logic [TAG_W-1:0]  head_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DEPTH-1:0]  exclude_i,
    output logic              hit_o,
    output logic [TAG_W-1:0]  index_o
);

    logic [DEPTH-1:0] cand;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cand
            assign cand[gi] = entries_i[gi].valid && !entries_i[gi].done &&
                              (entries_i[gi].pc == pc_i) && !exclude_i[gi];
        end
    endgenerate

    logic [TAG_W-1:0] best_age;

    always_comb begin
        hit_o    = 1'b0;
        index_o  = '0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand[i] && (!hit_o || rob_age(TAG_W'(i), head_i) < best_age)) begin
                hit_o    = 1'b1;
                index_o  = TAG_W'(i);
                best_age = rob_age(TAG_W'(i), head_i);
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at dispatch, mark done on PC-keyed
// completions from ALU/MUL/DIV, retire at most one done head entry per cycle.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ROB_Flush,
    input  logic              dispatch_valid,
    input  logic [DATA_W-1:0] dispatch_PC,
    input  logic [4:0]        dispatch_Rd,
    input  logic              dispatch_RegWrite,
    output logic [TAG_W-1:0]  dispatch_tag,
    output logic              rob_full,
    output logic              rob_empty,
    input  logic              alu_exec_done,
    input  logic [DATA_W-1:0] alu_exec_PC,
    input  logic [DATA_W-1:0] alu_exec_value,
    input  logic              mul_exec_done,
    input  logic [DATA_W-1:0] mul_exec_PC,
    input  logic [DATA_W-1:0] mul_exec_value,
    input  logic              div_exec_done,
    input  logic [DATA_W-1:0] div_exec_PC,
    input  logic [DATA_W-1:0] div_exec_value,
    output logic              commit_valid,
    output logic [DATA_W-1:0] commit_PC,
    output logic [4:0]        commit_Rd,
    output logic              commit_RegWrite,
    output logic [DATA_W-1:0] commit_value
);

    rob_entry_t        entries_q [DEPTH];
    rob_entry_t        entries_d [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;

    logic              commit_valid_q;
    logic [DATA_W-1:0] commit_pc_q;
    logic [4:0]        commit_rd_q;
    logic              commit_regwrite_q;
    logic [DATA_W-1:0] commit_value_q;

    assign rob_full     = (count_q == (TAG_W+1)'(DEPTH));
    assign rob_empty    = (count_q == '0);
    assign dispatch_tag = tail_q;

    logic dispatch_accept;
    logic commit_fire;
    assign dispatch_accept = dispatch_valid && !rob_full;
    assign commit_fire     = entries_q[head_q].valid && entries_q[head_q].done;

    logic             alu_hit, mul_hit, div_hit;
    logic [TAG_W-1:0] alu_idx, mul_idx, div_idx;
    logic [DEPTH-1:0] alu_mask, mul_mask;

    // Chained exclusion lets same-PC completions claim successive oldest matches.
    assign alu_mask = alu_hit ? (DEPTH'(1) << alu_idx) : '0;
    assign mul_mask = mul_hit ? (DEPTH'(1) << mul_idx) : '0;

    rob_pc_match u_match_alu (
        .entries_i (entries_q),
        .head_i    (head_q),
        .pc_i      (alu_exec_PC),
        .exclude_i ({DEPTH{1'b0}}),
        .hit_o     (alu_hit),
        .index_o   (alu_idx)
    );

    rob_pc_match u_match_mul (
        .entries_i (entries_q),
        .head_i    (head_q),
        .pc_i      (mul_exec_PC),
        .exclude_i (alu_mask),
        .hit_o     (mul_hit),
        .index_o   (mul_idx)
    );

    rob_pc_match u_match_div (
        .entries_i (entries_q),
        .head_i    (head_q),
        .pc_i      (div_exec_PC),
        .exclude_i (alu_mask | mul_mask),
        .hit_o     (div_hit),
        .index_o   (div_idx)
    );

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (alu_exec_done && alu_hit) begin
            entries_d[alu_idx].done  = 1'b1;
            entries_d[alu_idx].value = alu_exec_value;
        end
        if (mul_exec_done && mul_hit) begin
            entries_d[mul_idx].done  = 1'b1;
            entries_d[mul_idx].value = mul_exec_value;
        end
        if (div_exec_done && div_hit) begin
            entries_d[div_idx].done  = 1'b1;
            entries_d[div_idx].value = div_exec_value;
        end

        if (commit_fire) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + 1'b1;
        end

        // The tail slot is never valid when a dispatch is accepted, so it cannot
        // have been matched above.
        if (dispatch_accept) begin
            entries_d[tail_q].valid    = 1'b1;
            entries_d[tail_q].done     = 1'b0;
            entries_d[tail_q].pc       = dispatch_PC;
            entries_d[tail_q].rd       = dispatch_Rd;
            entries_d[tail_q].regwrite = dispatch_RegWrite;
            entries_d[tail_q].value    = '0;
            tail_d                     = tail_q + 1'b1;
        end

        case ({dispatch_accept, commit_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
                entries_q[i].done  <= 1'b0;
            end
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            commit_valid_q    <= 1'b0;
            commit_pc_q       <= '0;
            commit_rd_q       <= '0;
            commit_regwrite_q <= 1'b0;
            commit_value_q    <= '0;
        end else if (ROB_Flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
                entries_q[i].done  <= 1'b0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_fire;
            if (commit_fire) begin
                commit_pc_q       <= entries_q[head_q].pc;
                commit_rd_q       <= entries_q[head_q].rd;
                commit_regwrite_q <= entries_q[head_q].regwrite;
                commit_value_q    <= entries_q[head_q].value;
            end
        end
    end

    assign commit_valid    = commit_valid_q;
    assign commit_PC       = commit_pc_q;
    assign commit_Rd       = commit_rd_q;
    assign commit_RegWrite = commit_regwrite_q;
    assign commit_value    = commit_value_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued as
// completions are driven and checked in order as commit pulses appear.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset, ROB_Flush;
    logic        dispatch_valid;
    logic [31:0] dispatch_PC;
    logic [4:0]  dispatch_Rd;
    logic        dispatch_RegWrite;
    logic [2:0]  dispatch_tag;
    logic        rob_full, rob_empty;
    logic        alu_exec_done, mul_exec_done, div_exec_done;
    logic [31:0] alu_exec_PC, mul_exec_PC, div_exec_PC;
    logic [31:0] alu_exec_value, mul_exec_value, div_exec_value;
    logic        commit_valid;
    logic [31:0] commit_PC;
    logic [4:0]  commit_Rd;
    logic        commit_RegWrite;
    logic [31:0] commit_value;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .ROB_Flush         (ROB_Flush),
        .dispatch_valid    (dispatch_valid),
        .dispatch_PC       (dispatch_PC),
        .dispatch_Rd       (dispatch_Rd),
        .dispatch_RegWrite (dispatch_RegWrite),
        .dispatch_tag      (dispatch_tag),
        .rob_full          (rob_full),
        .rob_empty         (rob_empty),
        .alu_exec_done     (alu_exec_done),
        .alu_exec_PC       (alu_exec_PC),
        .alu_exec_value    (alu_exec_value),
        .mul_exec_done     (mul_exec_done),
        .mul_exec_PC       (mul_exec_PC),
        .mul_exec_value    (mul_exec_value),
        .div_exec_done     (div_exec_done),
        .div_exec_PC       (div_exec_PC),
        .div_exec_value    (div_exec_value),
        .commit_valid      (commit_valid),
        .commit_PC         (commit_PC),
        .commit_Rd         (commit_Rd),
        .commit_RegWrite   (commit_RegWrite),
        .commit_value      (commit_value)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [4:0] rd,
                            input logic rw, input logic [31:0] value);
        exp_t e;
        e.pc = pc; e.rd = rd; e.rw = rw; e.value = value;
        exp_q.push_back(e);
    endtask

    // Retirement monitor: every commit pulse must match the queue head.
    always @(negedge clk) begin
        if (commit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_commit_pc", commit_PC, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("commit pc=0x%08h rd=%0d rw=%0b value=0x%08h", commit_PC, commit_Rd,
                         commit_RegWrite, commit_value);
                check_eq("commit_pc", commit_PC, e.pc);
                check_eq("commit_rd", 32'(commit_Rd), 32'(e.rd));
                check_eq("commit_rw", 32'(commit_RegWrite), 32'(e.rw));
                check_eq("commit_value", commit_value, e.value);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic dispatch(input logic [31:0] pc, input logic [4:0] rd, input logic rw);
        dispatch_valid = 1'b1; dispatch_PC = pc; dispatch_Rd = rd; dispatch_RegWrite = rw;
        tick();
        dispatch_valid = 1'b0;
    endtask

    task automatic complete(input logic a, input logic [31:0] apc, input logic [31:0] aval,
                            input logic m, input logic [31:0] mpc, input logic [31:0] mval,
                            input logic d, input logic [31:0] dpc, input logic [31:0] dval);
        alu_exec_done = a; alu_exec_PC = apc; alu_exec_value = aval;
        mul_exec_done = m; mul_exec_PC = mpc; mul_exec_value = mval;
        div_exec_done = d; div_exec_PC = dpc; div_exec_value = dval;
        tick();
        alu_exec_done = 1'b0; mul_exec_done = 1'b0; div_exec_done = 1'b0;
    endtask

    task automatic alu(input logic [31:0] pc, input logic [31:0] val);
        complete(1'b1, pc, val, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic flush();
        ROB_Flush = 1'b1;
        tick();
        ROB_Flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ROB_Flush = 1'b0;
        dispatch_valid = 1'b0; dispatch_PC = '0; dispatch_Rd = '0; dispatch_RegWrite = 1'b0;
        alu_exec_done = 1'b0; alu_exec_PC = '0; alu_exec_value = '0;
        mul_exec_done = 1'b0; mul_exec_PC = '0; mul_exec_value = '0;
        div_exec_done = 1'b0; div_exec_PC = '0; div_exec_value = '0;
        idle(2);
        reset = 1'b0;

        check_eq("reset_empty", 32'(rob_empty), 32'd1);
        check_eq("reset_full", 32'(rob_full), 32'd0);
        check_eq("reset_tag", 32'(dispatch_tag), 32'd0);
        check_eq("reset_commit_valid", 32'(commit_valid), 32'd0);

        // In-order retirement despite out-of-order completion.
        dispatch(32'h00, 5'd1, 1'b1);
        dispatch(32'h04, 5'd2, 1'b1);
        dispatch(32'h08, 5'd3, 1'b0);
        check_eq("t1_tag", 32'(dispatch_tag), 32'd3);
        alu(32'h04, 32'd5);
        idle(2);
        check_eq("t1_no_early_commit_empty", 32'(rob_empty), 32'd0);
        push_exp(32'h00, 5'd1, 1'b1, 32'd7);
        push_exp(32'h04, 5'd2, 1'b1, 32'd5);
        alu(32'h00, 32'd7);
        idle(4);
        check_eq("t1_drain", 32'(exp_q.size()), 32'd0);
        check_eq("t1_not_empty", 32'(rob_empty), 32'd0);
        flush();
        check_eq("t1_flush_empty", 32'(rob_empty), 32'd1);

        // Fill, drop on full, wrap-around allocation.
        for (int i = 0; i < 8; i++) dispatch(32'h100 + 32'(i * 4), 5'(i + 8), 1'b1);
        check_eq("t2_full", 32'(rob_full), 32'd1);
        check_eq("t2_full_tag", 32'(dispatch_tag), 32'd0);
        dispatch(32'h20, 5'd9, 1'b1);
        check_eq("t2_drop_full", 32'(rob_full), 32'd1);
        check_eq("t2_drop_tag", 32'(dispatch_tag), 32'd0);
        push_exp(32'h100, 5'd8, 1'b1, 32'h55);
        alu(32'h100, 32'h55);
        tick();
        check_eq("t2_after_commit_full", 32'(rob_full), 32'd0);
        check_eq("t2_wrap_tag", 32'(dispatch_tag), 32'd0);
        dispatch(32'h20, 5'd9, 1'b1);
        check_eq("t2_refill_full", 32'(rob_full), 32'd1);
        check_eq("t2_refill_tag", 32'(dispatch_tag), 32'd1);
        idle(2);
        check_eq("t2_drain", 32'(exp_q.size()), 32'd0);
        flush();

        // Three ports completing in the same cycle.
        dispatch(32'h10, 5'd4, 1'b1);
        dispatch(32'h14, 5'd5, 1'b1);
        dispatch(32'h18, 5'd6, 1'b1);
        push_exp(32'h10, 5'd4, 1'b1, 32'd1);
        push_exp(32'h14, 5'd5, 1'b1, 32'd2);
        push_exp(32'h18, 5'd6, 1'b1, 32'd3);
        complete(1'b1, 32'h10, 32'd1, 1'b1, 32'h14, 32'd2, 1'b1, 32'h18, 32'd3);
        idle(5);
        check_eq("t3_drain", 32'(exp_q.size()), 32'd0);
        check_eq("t3_empty", 32'(rob_empty), 32'd1);

        // Duplicate PCs: ALU claims the older entry, MUL the younger.
        dispatch(32'h40, 5'd5, 1'b1);
        dispatch(32'h40, 5'd6, 1'b1);
        push_exp(32'h40, 5'd5, 1'b1, 32'hA);
        push_exp(32'h40, 5'd6, 1'b1, 32'hB);
        complete(1'b1, 32'h40, 32'hA, 1'b1, 32'h40, 32'hB, 1'b0, 32'h0, 32'h0);
        idle(4);
        check_eq("t4_drain", 32'(exp_q.size()), 32'd0);

        // Flush beats a concurrent dispatch and completion.
        for (int i = 0; i < 4; i++) dispatch(32'h200 + 32'(i * 4), 5'(i), 1'b1);
        alu(32'h204, 32'h1);
        alu(32'h208, 32'h2);
        ROB_Flush = 1'b1;
        dispatch_valid = 1'b1; dispatch_PC = 32'h300; dispatch_Rd = 5'd7; dispatch_RegWrite = 1'b1;
        alu_exec_done = 1'b1; alu_exec_PC = 32'h200; alu_exec_value = 32'h3;
        tick();
        ROB_Flush = 1'b0; dispatch_valid = 1'b0; alu_exec_done = 1'b0;
        check_eq("t5_empty", 32'(rob_empty), 32'd1);
        check_eq("t5_tag", 32'(dispatch_tag), 32'd0);
        check_eq("t5_commit_valid", 32'(commit_valid), 32'd0);
        check_eq("t5_commit_pc_held", commit_PC, 32'h40);
        check_eq("t5_commit_value_held", commit_value, 32'hB);
        idle(3);

        // Unknown-PC completion has no effect.
        dispatch(32'h50, 5'd10, 1'b1);
        alu(32'h99, 32'hDEAD);
        idle(2);
        check_eq("t6_unknown_empty", 32'(rob_empty), 32'd0);
        check_eq("t6_unknown_tag", 32'(dispatch_tag), 32'd1);
        push_exp(32'h50, 5'd10, 1'b1, 32'h77);
        alu(32'h50, 32'h77);
        idle(2);

        // Minimum latency: dispatch E0, complete E1, commit visible after E2.
        dispatch(32'h60, 5'd11, 1'b0);
        dispatch_valid = 1'b1; dispatch_PC = 32'h64; dispatch_Rd = 5'd12; dispatch_RegWrite = 1'b1;
        alu_exec_done = 1'b1; alu_exec_PC = 32'h60; alu_exec_value = 32'h1234;
        push_exp(32'h60, 5'd11, 1'b0, 32'h1234);
        tick();
        dispatch_valid = 1'b0; alu_exec_done = 1'b0;
        check_eq("t6_lat_e1", 32'(commit_valid), 32'd0);
        tick();
        check_eq("t6_lat_e2", 32'(commit_valid), 32'd1);

        // Reset mid-stream with 0x64 still in flight.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t7_commit_valid", 32'(commit_valid), 32'd0);
        check_eq("t7_commit_pc", commit_PC, 32'd0);
        check_eq("t7_commit_rd", 32'(commit_Rd), 32'd0);
        check_eq("t7_commit_rw", 32'(commit_RegWrite), 32'd0);
        check_eq("t7_commit_value", commit_value, 32'd0);
        check_eq("t7_empty", 32'(rob_empty), 32'd1);
        check_eq("t7_tag", 32'(dispatch_tag), 32'd0);
        idle(2);
        check_eq("final_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
